matriz_scan_ctrl: RTL and testbench
===================================

// Module: matriz_scan_ctrl
// PURPOSE
//  Parametrised LED-matrix scan controller; drives the board matrix from a flat bitmap.
//  Adds over the fixed 7x5 displayer: N_ROWS x N_COLS geometry, a double-buffered frame with
//  valid/ready load, tear-free swap at frame end, per-pixel blink mask, and anti-ghost blanking.
//  Sits between game logic (ship/shot map) and the matrix pins.
// PARAMETERS
//  N_ROWS        7     row lines (linha_matriz width)
//  N_COLS        5     column lines (coluna_matriz width)
//  SCAN_DIV      1000  cpld_clk cycles a column is driven (>=1)
//  BLANK_CYCLES  8     cycles all-off before each column (0 = no blanking)
//  BLINK_FRAMES  25    full frames per blink half-period (>=1)
//  ROW_ACT_LOW   1     1: lit row = 0 on linha_matriz
//  COL_ACT_LOW   0     1: selected column = 0 on coluna_matriz
// PORTS
//  cpld_clk       in   1              system clock
//  reset          in   1              async, active-high
//  map_in         in   N_ROWS*N_COLS  pixel data; bit c*N_ROWS+r = row r, col c
//  blink_in       in   N_ROWS*N_COLS  1 = pixel blinks (lit only in blink_phase=1)
//  load_valid     in   1              map_in/blink_in valid
//  load_ready     out  1              pending buffer free
//  linha_matriz   out  N_ROWS         row drive
//  coluna_matriz  out  N_COLS         one-hot column select
//  frame_start    out  1              1-cycle pulse, first BLANK/DRIVE cycle of column 0
//  blink_phase    out  1              current blink half
// BEHAVIOUR
//  Interface: one clock cpld_clk; reset asynchronous, active-high.
//  Reset: active/pending buffers = 0, pending empty, load_ready=1, col=0, state=BLANK (DRIVE
//   if BLANK_CYCLES=0), counters 0, blink_phase=0, frame_start=0, rows/cols at inactive level.
//   Reset mid-frame discards pending and active contents immediately.
//  Load: transfer when load_valid&&load_ready; map_in/blink_in captured into pending,
//   pending marked full, load_ready=0 from next cycle. No bypass into active buffer.
//  FSM per column: BLANK (BLANK_CYCLES cycles, rows and cols all inactive) -> DRIVE (SCAN_DIV
//   cycles). DRIVE: coluna_matriz one-hot at col; row r lit iff act_map[col*N_ROWS+r] &&
//   (!act_blink[..] || blink_phase). Polarity per ROW_ACT_LOW/COL_ACT_LOW.
//  Outputs registered: pins change 1 cycle after the state/col update that selects them.
//  Column wrap: last cycle of DRIVE at col=N_COLS-1 is frame end: col->0; if pending full,
//   active<=pending, pending empty, load_ready=1 next cycle; frame counter++ and at
//   BLINK_FRAMES wraps to 0 and blink_phase toggles. frame_start pulses on the following cycle.
//  Load accepted on the frame-end cycle itself (pending was empty): goes to pending, shown at
//   the NEXT frame end. Latency load->visible: up to 2 frames.
//  Widths: counters $clog2 of their limit (min 1 bit); no overflow past limits.
//  load_valid may drop without transfer; no data held on input side.
// STRUCTURE
//  Shared package batalha_pkg: pixel index function idx(r,c)=c*N_ROWS+r, polarity
//   constants, FSM state typedef {ST_BLANK, ST_DRIVE}.
//  One sub-module: scan_timer (dwell counter + column index + frame-end pulse), instantiated
//   once; buffers, blink logic and pin drive in the top.
// TESTING  (N_ROWS=7,N_COLS=5,SCAN_DIV=4,BLANK_CYCLES=1,BLINK_FRAMES=2, active-high both)
//  Reset: assert reset mid-DRIVE -> same cycle cols=0, rows=0, load_ready=1, blink_phase=0.
//  Single pixel: load map bit 8 (r1,c1) -> after frame end, col1 DRIVE shows linha=0000010,
//   every other column 0; each column = 1 blank + 4 drive cycles; frame = 25 cycles.
//  Double buffer: load A, then B before frame end -> second load stalls (load_ready=0) until
//   A swaps; B visible one frame after A; no column of any frame mixes A and B.
//  Blink: map=all 1, blink mask bit 0 -> pixel r0,c0 off for 2 frames, on for 2 frames,
//   other pixels steady; blink_phase toggles every 50 cycles.
//  Frame-end load: load_valid on exact frame-end cycle -> accepted, visible only after the
//   next frame end (frame_start count +2).
//  Active-low build (ROW_ACT_LOW=1,COL_ACT_LOW=1): blanking drives all 1s; selected col = 0.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared definitions for the LED-matrix scan path: scan FSM states, pin polarity
// constants and the flat-bitmap pixel indexing used by the game logic.
package batalha_pkg;

  typedef enum logic [0:0] {
    ST_BLANK,
    ST_DRIVE
  } scan_state_t;

  localparam bit POL_ACT_HIGH = 1'b0;
  localparam bit POL_ACT_LOW  = 1'b1;

  // Flat bitmap layout: column-major, N_ROWS pixels per column.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned n_rows);
    return c * n_rows + r;
  endfunction

  // Counter width for values 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    if (limit <= 1) return 1;
    return unsigned'($clog2(limit));
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Column sequencer: BLANK then DRIVE dwell per column, column index and a
// single-cycle frame_end flag on the last DRIVE cycle of the last column.
module scan_timer
  import batalha_pkg::*;
#(
  parameter int unsigned N_COLS       = 5,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  localparam int unsigned ColW        = cnt_width(N_COLS)
) (
  input  logic              cpld_clk,
  input  logic              reset,
  output scan_state_t       state,
  output logic [ColW-1:0]   col,
  output logic              frame_end
);

  localparam int unsigned DwellMax = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CntW     = cnt_width(DwellMax);

  localparam logic [CntW-1:0] DriveLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [ColW-1:0] ColLast   = ColW'(N_COLS - 1);

  // Each column starts in BLANK unless blanking is disabled.
  localparam scan_state_t EntrySt = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  scan_state_t      state_q;
  logic [ColW-1:0]  col_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge cpld_clk or posedge reset) begin
    if (reset) begin
      state_q <= EntrySt;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == BlankLast) begin
            cnt_q   <= '0;
            state_q <= ST_DRIVE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DriveLast) begin
            cnt_q   <= '0;
            state_q <= EntrySt;
            col_q   <= (col_q == ColLast) ? '0 : col_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= EntrySt;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign col       = col_q;
  assign frame_end = (state_q == ST_DRIVE) && (cnt_q == DriveLast) && (col_q == ColLast);

endmodule

// File: rtl/matriz_scan_ctrl.sv
// LED-matrix scan controller: double-buffered bitmap with tear-free swap at frame end,
// per-pixel blink mask, anti-ghost blanking and registered row/column pin drive.
module matriz_scan_ctrl
  import batalha_pkg::*;
#(
  parameter int unsigned N_ROWS       = 7,
  parameter int unsigned N_COLS       = 5,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned BLINK_FRAMES = 25,
  parameter bit          ROW_ACT_LOW  = 1'b1,
  parameter bit          COL_ACT_LOW  = 1'b0
) (
  input  logic                       cpld_clk,
  input  logic                       reset,
  input  logic [N_ROWS*N_COLS-1:0]   map_in,
  input  logic [N_ROWS*N_COLS-1:0]   blink_in,
  input  logic                       load_valid,
  output logic                       load_ready,
  output logic [N_ROWS-1:0]          linha_matriz,
  output logic [N_COLS-1:0]          coluna_matriz,
  output logic                       frame_start,
  output logic                       blink_phase
);

  localparam int unsigned NPix = N_ROWS * N_COLS;
  localparam int unsigned ColW = cnt_width(N_COLS);
  localparam int unsigned FrmW = cnt_width(BLINK_FRAMES);

  localparam logic [FrmW-1:0]   FrmLast = FrmW'(BLINK_FRAMES - 1);
  localparam bit                RowInv  = (ROW_ACT_LOW == POL_ACT_LOW);
  localparam bit                ColInv  = (COL_ACT_LOW == POL_ACT_LOW);
  localparam logic [N_ROWS-1:0] RowIdle = {N_ROWS{RowInv}};
  localparam logic [N_COLS-1:0] ColIdle = {N_COLS{ColInv}};

  scan_state_t      state;
  logic [ColW-1:0]  col;
  logic             frame_end;

  scan_timer #(
    .N_COLS       (N_COLS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .cpld_clk  (cpld_clk),
    .reset     (reset),
    .state     (state),
    .col       (col),
    .frame_end (frame_end)
  );

  // Frame buffers
  logic [NPix-1:0] pend_map_q, pend_blink_q;
  logic [NPix-1:0] act_map_q, act_blink_q;
  logic            pend_full_q;
  logic            load_fire;

  assign load_ready = ~pend_full_q;
  assign load_fire  = load_valid & ~pend_full_q;

  always_ff @(posedge cpld_clk or posedge reset) begin
    if (reset) begin
      pend_map_q   <= '0;
      pend_blink_q <= '0;
      act_map_q    <= '0;
      act_blink_q  <= '0;
      pend_full_q  <= 1'b0;
    end else begin
      if (load_fire) begin
        pend_map_q   <= map_in;
        pend_blink_q <= blink_in;
      end
      // Swap only at frame end so no frame ever shows a mix of two bitmaps.
      if (frame_end && pend_full_q) begin
        act_map_q   <= pend_map_q;
        act_blink_q <= pend_blink_q;
      end
      // A load on the frame-end cycle itself lands in pending and waits a full frame.
      if (load_fire) begin
        pend_full_q <= 1'b1;
      end else if (frame_end) begin
        pend_full_q <= 1'b0;
      end
    end
  end

  // Frame counting and blink phase
  logic [FrmW-1:0] frm_q;
  logic            blink_phase_q;
  logic            frame_start_q;

  always_ff @(posedge cpld_clk or posedge reset) begin
    if (reset) begin
      frm_q         <= '0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_end;
      if (frame_end) begin
        if (frm_q == FrmLast) begin
          frm_q         <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frm_q <= frm_q + 1'b1;
        end
      end
    end
  end

  assign frame_start = frame_start_q;
  assign blink_phase = blink_phase_q;

  // Pin drive
  logic [N_ROWS-1:0] map_cols   [N_COLS];
  logic [N_ROWS-1:0] blink_cols [N_COLS];

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    assign map_cols[c]   = act_map_q[idx(0, c, N_ROWS) +: N_ROWS];
    assign blink_cols[c] = act_blink_q[idx(0, c, N_ROWS) +: N_ROWS];
  end

  logic [N_ROWS-1:0] row_lit;
  logic [N_COLS-1:0] col_sel;

  always_comb begin
    row_lit = '0;
    col_sel = '0;
    if (state == ST_DRIVE) begin
      col_sel = N_COLS'(1) << col;
      row_lit = map_cols[col] & (~blink_cols[col] | {N_ROWS{blink_phase_q}});
    end
  end

  logic [N_ROWS-1:0] linha_q;
  logic [N_COLS-1:0] coluna_q;

  always_ff @(posedge cpld_clk or posedge reset) begin
    if (reset) begin
      linha_q  <= RowIdle;
      coluna_q <= ColIdle;
    end else begin
      linha_q  <= RowInv ? ~row_lit : row_lit;
      coluna_q <= ColInv ? ~col_sel : col_sel;
    end
  end

  assign linha_matriz  = linha_q;
  assign coluna_matriz = coluna_q;

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Directed bench for matriz_scan_ctrl: 7x5, 1 blank + 4 drive cycles per column,
// blink half-period of 2 frames; an active-high and an active-low build run in lock-step.
module tb_matriz_scan_ctrl;

  localparam int NR = 7;
  localparam int NC = 5;
  localparam int NP = NR * NC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] map_in = '0;
  logic [NP-1:0] blink_in = '0;
  logic          load_valid = 1'b0;

  logic          load_ready, load_ready_lo;
  logic [NR-1:0] linha, linha_lo;
  logic [NC-1:0] coluna, coluna_lo;
  logic          frame_start, frame_start_lo;
  logic          blink_phase, blink_phase_lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matriz_scan_ctrl #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2),
    .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b0)
  ) u_dut (
    .cpld_clk(clk), .reset(reset), .map_in(map_in), .blink_in(blink_in),
    .load_valid(load_valid), .load_ready(load_ready), .linha_matriz(linha),
    .coluna_matriz(coluna), .frame_start(frame_start), .blink_phase(blink_phase)
  );

  matriz_scan_ctrl #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2),
    .ROW_ACT_LOW(1'b1), .COL_ACT_LOW(1'b1)
  ) u_dut_lo (
    .cpld_clk(clk), .reset(reset), .map_in(map_in), .blink_in(blink_in),
    .load_valid(load_valid), .load_ready(load_ready_lo), .linha_matriz(linha_lo),
    .coluna_matriz(coluna_lo), .frame_start(frame_start_lo), .blink_phase(blink_phase_lo)
  );

  function automatic logic [NR-1:0] exp_rows(input logic [NP-1:0] m, input logic [NP-1:0] b,
                                             input logic ph, input int c);
    logic [NR-1:0] e;
    for (int r = 0; r < NR; r++) e[r] = m[c*NR + r] & (~b[c*NR + r] | ph);
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at a negedge where frame_start is high; checks the current cycle first.
  task automatic wait_fs(input string name);
    for (int i = 0; i < 60; i++) begin
      if (frame_start === 1'b1) return;
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s wait: got no frame_start want pulse within 60 cycles", name);
  endtask

  task automatic do_load(input logic [NP-1:0] m, input logic [NP-1:0] b, output int waited);
    @(negedge clk);
    map_in = m;
    blink_in = b;
    load_valid = 1'b1;
    waited = 0;
    while (load_ready !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (load_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL load timeout: got load_ready=%b want 1", load_ready);
      waited = -1;
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Checks one whole frame of pins on both builds starting at the next frame_start.
  task automatic check_frame(input logic [NP-1:0] m, input logic [NP-1:0] b, input logic ph,
                             input string name);
    logic [NR-1:0] er;
    logic [NC-1:0] ec;
    wait_fs(name);
    n_cmp++;
    if (blink_phase !== ph) begin
      n_err++;
      $display("FAIL %s phase: got %b want %b", name, blink_phase, ph);
    end
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 0) begin
          er = '0;
          ec = '0;
        end else begin
          er = exp_rows(m, b, ph, c);
          ec = 5'b00001 << c;
        end
        if (c == 0 && k == 0) begin
          n_cmp++;
          if (frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse width: got frame_start=%b want 0", name, frame_start);
          end
        end
        n_cmp++;
        if ({linha, coluna} !== {er, ec}) begin
          n_err++;
          $display("FAIL %s col%0d cyc%0d: got linha=%b coluna=%b want linha=%b coluna=%b",
                   name, c, k, linha, coluna, er, ec);
        end
        n_cmp++;
        if ({linha_lo, coluna_lo} !== {~er, ~ec}) begin
          n_err++;
          $display("FAIL %s lo col%0d cyc%0d: got linha=%b coluna=%b want linha=%b coluna=%b",
                   name, c, k, linha_lo, coluna_lo, ~er, ~ec);
        end
      end
    end
  endtask

  task automatic test_single_pixel();
    logic [NP-1:0] m;
    int w;
    m = '0;
    m[8] = 1'b1;
    apply_reset();
    do_load(m, '0, w);
    n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pixel ready after load: got %b want 0", load_ready);
    end
    check_frame(m, '0, 1'b0, "pixel f1");
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pixel ready after swap: got %b want 1", load_ready);
    end
  endtask

  // Continues from the single-pixel frame 2; reset lands in column 1 DRIVE.
  task automatic test_reset();
    int w;
    wait_fs("reset sync");
    do_load({NP{1'b1}}, '0, w);
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({linha, coluna, load_ready, blink_phase} !== {7'b0000010, 5'b00010, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset precond: got %b/%b/%b/%b want 0000010/00010/0/1",
               linha, coluna, load_ready, blink_phase);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({linha, coluna, load_ready, blink_phase, frame_start} !==
        {7'b0, 5'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset hi: got linha=%b coluna=%b rdy=%b ph=%b fs=%b want 0/0/1/0/0",
               linha, coluna, load_ready, blink_phase, frame_start);
    end
    n_cmp++;
    if ({linha_lo, coluna_lo, load_ready_lo} !== {7'h7F, 5'h1F, 1'b1}) begin
      n_err++;
      $display("FAIL reset lo: got linha=%b coluna=%b rdy=%b want 1111111/11111/1",
               linha_lo, coluna_lo, load_ready_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    // Pending and active were both discarded, so the next frame must be dark.
    check_frame('0, '0, 1'b0, "reset f1");
  endtask

  task automatic test_double_buffer();
    logic [NP-1:0] a, b;
    int w, wb;
    a = 35'h1_2345_6789;
    b = 35'h6_DCBA_9876;
    apply_reset();
    do_load(a, '0, w);
    n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL dbuf ready after A: got %b want 0", load_ready);
    end
    fork
      do_load(b, '0, wb);
      check_frame(a, '0, 1'b0, "dbuf A");
    join
    n_cmp++;
    if (wb != 22) begin
      n_err++;
      $display("FAIL dbuf stall: got %0d cycles want 22", wb);
    end
    check_frame(b, '0, 1'b1, "dbuf B");
  endtask

  task automatic test_blink();
    logic [NP-1:0] m, b;
    int w;
    m = '1;
    b = '0;
    b[0] = 1'b1;
    apply_reset();
    do_load(m, b, w);
    check_frame(m, b, 1'b0, "blink f1");
    check_frame(m, b, 1'b1, "blink f2");
    check_frame(m, b, 1'b1, "blink f3");
    check_frame(m, b, 1'b0, "blink f4");
  endtask

  task automatic test_frame_end_load();
    logic [NP-1:0] x;
    x = 35'h2_468A_CD55;
    apply_reset();
    wait_fs("fe sync");
    repeat (24) @(negedge clk);
    n_cmp++;
    if ({load_ready, frame_start} !== 2'b10) begin
      n_err++;
      $display("FAIL fe precond: got rdy=%b fs=%b want 1/0", load_ready, frame_start);
    end
    map_in = x;
    blink_in = '0;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    n_cmp++;
    if ({frame_start, load_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL fe accept: got fs=%b rdy=%b want 1/0", frame_start, load_ready);
    end
    check_frame('0, '0, 1'b1, "fe old");
    check_frame(x, '0, 1'b1, "fe new");
  endtask

  // Continues at the frame_start after the frame-end load became visible.
  task automatic test_active_low();
    @(negedge clk);
    n_cmp++;
    if ({linha_lo, coluna_lo, frame_start_lo, blink_phase_lo} !== {7'h7F, 5'h1F, 1'b0, 1'b0})
    begin
      n_err++;
      $display("FAIL lo blank: got %b/%b/%b/%b want 1111111/11111/0/0",
               linha_lo, coluna_lo, frame_start_lo, blink_phase_lo);
    end
    @(negedge clk);
    n_cmp++;
    if ({linha_lo, coluna_lo} !== {7'b0101010, 5'b11110}) begin
      n_err++;
      $display("FAIL lo drive: got %b/%b want 0101010/11110", linha_lo, coluna_lo);
    end
  endtask

  initial begin
    test_single_pixel();
    test_reset();
    test_double_buffer();
    test_blink();
    test_frame_end_load();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
